// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised/deglitched inputs, 11-bit frame decode, FWFT output FIFO.
// Optional statistics counters are enabled by defining PS2_RX_STATS_EN.
module ps2_rx_fifo #(
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 5000,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned LVL_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ps2_clk_i,
   input  logic             ps2_data_i,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic [LVL_W-1:0] fifo_level,
   output logic             err_parity,
   output logic             err_frame,
   output logic             overflow,
`ifdef PS2_RX_STATS_EN
   input  logic             stat_clr,
   output logic [15:0]      stat_ok,
   output logic [15:0]      stat_perr,
   output logic [15:0]      stat_ferr,
   output logic [15:0]      stat_ovf,
`endif
   output logic             busy
);

   localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t r_state, w_next;

   logic [1:0]       r_clk_sync, r_dat_sync;
   logic [FLT_W-1:0] r_clk_fcnt, r_dat_fcnt;
   logic             r_clk_filt, r_dat_filt, r_clk_filt_d;
   logic             w_fall;
   logic [TO_W-1:0]  r_to_cnt;
   logic             w_timeout;
   logic [7:0]       r_sreg;
   logic [2:0]       r_bit_cnt;
   logic             r_par;
   logic             w_push_req, w_perr, w_ferr;
   logic             w_full, w_pop, w_wr, w_ovf;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_err_parity, r_err_frame, r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
         r_dat_sync <= {r_dat_sync[0], ps2_data_i};
      end
   end

   // Filtered level flips only after FILTER_LEN consecutive samples disagree with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_filt <= 1'b1;
         r_clk_fcnt <= '0;
      end else if (r_clk_sync[1] == r_clk_filt) begin
         r_clk_fcnt <= '0;
      end else if (r_clk_fcnt == FLT_W'(FILTER_LEN - 1)) begin
         r_clk_filt <= r_clk_sync[1];
         r_clk_fcnt <= '0;
      end else begin
         r_clk_fcnt <= r_clk_fcnt + FLT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dat_filt <= 1'b1;
         r_dat_fcnt <= '0;
      end else if (r_dat_sync[1] == r_dat_filt) begin
         r_dat_fcnt <= '0;
      end else if (r_dat_fcnt == FLT_W'(FILTER_LEN - 1)) begin
         r_dat_filt <= r_dat_sync[1];
         r_dat_fcnt <= '0;
      end else begin
         r_dat_fcnt <= r_dat_fcnt + FLT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clk_filt_d <= 1'b1;
      else        r_clk_filt_d <= r_clk_filt;
   end

   assign w_fall = r_clk_filt_d & ~r_clk_filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_to_cnt <= '0;
      else if (r_state == S_IDLE || w_fall)   r_to_cnt <= '0;
      else if (r_to_cnt != TO_W'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + TO_W'(1);
   end

   assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_fall && !r_dat_filt) w_next = S_START;
         S_START:  w_next = S_DATA;
         S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_next = S_PARITY;
         S_PARITY: if (w_fall) w_next = S_STOP;
         S_STOP:   if (w_fall) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_IDLE;
   end

   always_comb begin
      w_push_req = 1'b0;
      w_perr     = 1'b0;
      w_ferr     = 1'b0;
      busy       = (r_state != S_IDLE);
      if (w_timeout) begin
         w_ferr = 1'b1;
      end else if (r_state == S_STOP && w_fall) begin
         if (!r_dat_filt)                w_ferr     = 1'b1;
         else if (^{r_sreg, r_par} == 1'b0) w_perr  = 1'b1;
         else                            w_push_req = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
      end else if (w_timeout) begin
         r_sreg    <= '0;
         r_bit_cnt <= '0;
      end else begin
         case (r_state)
            S_START: r_bit_cnt <= '0;
            S_DATA: if (w_fall) begin
               r_sreg    <= {r_dat_filt, r_sreg[7:1]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            S_PARITY: if (w_fall) r_par <= r_dat_filt;
            default: ;
         endcase
      end
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_pop  = rx_ready & (r_level != '0);
   assign w_wr   = w_push_req & (~w_full | w_pop);
   assign w_ovf  = w_push_req & w_full & ~w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr) begin
         r_mem[r_wr_ptr] <= r_sreg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_parity <= 1'b0;
         r_err_frame  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_err_parity <= w_perr;
         r_err_frame  <= w_ferr;
         r_overflow   <= w_ovf;
      end
   end

   assign rx_data    = r_mem[r_rd_ptr];
   assign rx_valid   = (r_level != '0);
   assign fifo_level = r_level;
   assign err_parity = r_err_parity;
   assign err_frame  = r_err_frame;
   assign overflow   = r_overflow;

`ifdef PS2_RX_STATS_EN
   logic [15:0] r_stat_ok, r_stat_perr, r_stat_ferr, r_stat_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_ok   <= '0;
         r_stat_perr <= '0;
         r_stat_ferr <= '0;
         r_stat_ovf  <= '0;
      end else if (stat_clr) begin
         r_stat_ok   <= '0;
         r_stat_perr <= '0;
         r_stat_ferr <= '0;
         r_stat_ovf  <= '0;
      end else begin
         if (w_wr   && r_stat_ok   != '1) r_stat_ok   <= r_stat_ok   + 16'd1;
         if (w_perr && r_stat_perr != '1) r_stat_perr <= r_stat_perr + 16'd1;
         if (w_ferr && r_stat_ferr != '1) r_stat_ferr <= r_stat_ferr + 16'd1;
         if (w_ovf  && r_stat_ovf  != '1) r_stat_ovf  <= r_stat_ovf  + 16'd1;
      end
   end

   assign stat_ok   = r_stat_ok;
   assign stat_perr = r_stat_perr;
   assign stat_ferr = r_stat_ferr;
   assign stat_ovf  = r_stat_ovf;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames driven on the pads, popped bytes and error pulses checked.
module tb_ps2_rx_fifo;
   localparam int unsigned FL = 4;
   localparam int unsigned TO = 200;
   localparam int unsigned FD = 4;
   localparam int unsigned LW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ps2_clk_i, ps2_data_i, rx_ready;
   logic [7:0]    rx_data;
   logic          rx_valid, err_parity, err_frame, overflow, busy;
   logic [LW-1:0] fifo_level;
`ifdef PS2_RX_STATS_EN
   logic          stat_clr;
   logic [15:0]   stat_ok, stat_perr, stat_ferr, stat_ovf;
`endif

   ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD), .LVL_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
      .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow),
`ifdef PS2_RX_STATS_EN
      .stat_clr(stat_clr), .stat_ok(stat_ok), .stat_perr(stat_perr),
      .stat_ferr(stat_ferr), .stat_ovf(stat_ovf),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [7:0]  exp_q[$];
   int          n_perr = 0, n_ferr = 0, n_ovf = 0, n_valid_cyc = 0;
   int unsigned valid_rise_cyc = 0, ferr_cyc = 0, last_fall_cyc = 0;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      if (err_parity) n_perr++;
      if (err_frame) begin
         n_ferr++;
         ferr_cyc = cyc;
      end
      if (overflow) n_ovf++;
      if (rx_valid) n_valid_cyc++;
      if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = rx_valid;
      if (rx_valid && rx_ready) begin
         if (exp_q.size() == 0) check_val("sb_nonempty", 0, 1);
         else                   check_val("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // nbits < 11 aborts the frame early; glitch_bit/rst_bit < 0 disable those disturbances
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                             input int nbits, input int glitch_bit, input int rst_bit);
      logic [10:0] b;
      b = {stop_bit, (~^d) ^ par_flip, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data_i = b[i];
         if (i == glitch_bit) begin
            repeat (2) tick();
            ps2_clk_i = 1'b0;
            repeat (3) tick();
            ps2_clk_i = 1'b1;
            repeat (2) tick();
            ps2_data_i = ~b[i];
            repeat (3) tick();
            ps2_data_i = b[i];
         end
         repeat (10) tick();
         ps2_clk_i = 1'b0;
         last_fall_cyc = cyc;
         repeat (20) tick();
         ps2_clk_i = 1'b1;
         repeat (10) tick();
         if (i == rst_bit) begin
            check_val("pre_rst_busy", {31'd0, busy}, 1);
            check_val("pre_rst_level", {29'd0, fifo_level}, 1);
            rst_n = 1'b0;
            #2;
            check_val("rst_valid", {31'd0, rx_valid}, 0);
            check_val("rst_data", {24'd0, rx_data}, 0);
            check_val("rst_level", {29'd0, fifo_level}, 0);
            check_val("rst_busy", {31'd0, busy}, 0);
            exp_q.delete();
            tick();
            rst_n = 1'b1;
            ps2_data_i = 1'b1;
            repeat (20) tick();
            return;
         end
      end
      ps2_data_i = 1'b1;
      repeat (20) tick();
   endtask

   task automatic clear_counts;
      n_perr = 0;
      n_ferr = 0;
      n_ovf = 0;
      n_valid_cyc = 0;
   endtask

   initial begin
      int nb;
      rst_n = 1'b0;
      ps2_clk_i = 1'b1;
      ps2_data_i = 1'b1;
      rx_ready = 1'b0;
`ifdef PS2_RX_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("reset_valid", {31'd0, rx_valid}, 0);
      check_val("reset_data", {24'd0, rx_data}, 0);
      check_val("reset_level", {29'd0, fifo_level}, 0);
      check_val("reset_busy", {31'd0, busy}, 0);
      check_val("reset_errs", {29'd0, err_parity, err_frame, overflow}, 0);
      tick();

      // Test 1: good frame, popped immediately
      rx_ready = 1'b1;
      clear_counts();
      exp_q.push_back(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1);
      check_val("t1_latency", valid_rise_cyc - last_fall_cyc, 2 + FL + 1);
      check_val("t1_valid_cycles", n_valid_cyc, 1);
      check_val("t1_no_err", n_perr + n_ferr + n_ovf, 0);

      // Test 2: parity error, then good 0xF0
      clear_counts();
      send_frame(8'h1C, 1'b1, 1'b1, 11, -1, -1);
      check_val("t2_perr", n_perr, 1);
      check_val("t2_level", {29'd0, fifo_level}, 0);
      exp_q.push_back(8'hF0);
      send_frame(8'hF0, 1'b0, 1'b1, 11, -1, -1);
      check_val("t2_perr_after", n_perr, 1);

      // Test 3: stop error, timeout, then recovery
      clear_counts();
      send_frame(8'h55, 1'b0, 1'b0, 11, -1, -1);
      check_val("t3_ferr_stop", n_ferr, 1);
      check_val("t3_level", {29'd0, fifo_level}, 0);
      send_frame(8'h55, 1'b0, 1'b1, 6, -1, -1);
      check_val("t3_busy_mid", {31'd0, busy}, 1);
      repeat (230) tick();
      check_val("t3_ferr_timeout", n_ferr, 2);
      check_val("t3_timeout_time", {31'd0, (ferr_cyc - last_fall_cyc >= TO) &&
                                           (ferr_cyc - last_fall_cyc <= TO + 12)}, 1);
      check_val("t3_busy_after", {31'd0, busy}, 0);
      exp_q.push_back(8'h29);
      send_frame(8'h29, 1'b0, 1'b1, 11, -1, -1);
      check_val("t3_ferr_final", n_ferr, 2);

      // Test 4: fill past depth with consumer stalled
      clear_counts();
      rx_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k <= int'(FD)) exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b0, 1'b1, 11, -1, -1);
      end
      check_val("t4_level_full", {29'd0, fifo_level}, FD);
      check_val("t4_ovf", n_ovf, 1);
      check_val("t4_head", {24'd0, rx_data}, 1);
      rx_ready = 1'b1;
      for (int k = 0; k <= int'(FD); k++) begin
         @(negedge clk);
         check_val("t4_level_drain", {29'd0, fifo_level}, FD - k);
      end
      tick();
      check_val("t4_sb_empty", exp_q.size(), 0);

`ifdef PS2_RX_STATS_EN
      check_val("stat_ok", {16'd0, stat_ok}, 7);
      check_val("stat_perr", {16'd0, stat_perr}, 1);
      check_val("stat_ferr", {16'd0, stat_ferr}, 2);
      check_val("stat_ovf", {16'd0, stat_ovf}, 1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      check_val("stat_clr", {16'd0, stat_ok | stat_perr | stat_ferr | stat_ovf}, 0);
`endif

      // Test 5: short glitches in IDLE and mid-DATA
      clear_counts();
      ps2_clk_i = 1'b0;
      ps2_data_i = 1'b0;
      repeat (3) tick();
      ps2_clk_i = 1'b1;
      ps2_data_i = 1'b1;
      nb = 0;
      repeat (15) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check_val("t5_idle_busy", nb, 0);
      tick();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1, 11, 3, -1);
      check_val("t5_no_err", n_perr + n_ferr + n_ovf, 0);
      check_val("t5_sb_empty", exp_q.size(), 0);

      // Test 6: reset mid-frame with a byte held in the FIFO
      rx_ready = 1'b0;
      exp_q.push_back(8'h33);
      send_frame(8'h33, 1'b0, 1'b1, 11, -1, -1);
      send_frame(8'hA5, 1'b0, 1'b1, 11, -1, 4);
      rx_ready = 1'b1;
      exp_q.push_back(8'h76);
      send_frame(8'h76, 1'b0, 1'b1, 11, -1, -1);
      check_val("t6_sb_empty", exp_q.size(), 0);
      check_val("t6_level", {29'd0, fifo_level}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
